mac_feeder: RTL and testbench
=============================

// Module: mac_feeder
// PURPOSE
//   Streaming operand sequencer and result collector for the MAC accumulator.
//   Accepts (A,B) operand pairs on a valid/ready stream with a last flag.
//   Drives MAC En/Clr/Ain/Bin and captures the accumulated Cout at end of vector.
//   Returns the dot-product on a result valid/ready port, then clears the MAC.
//   Sits between the operand source (FIFO/DMA) and the MAC; MAC instantiated alongside.
// PARAMETERS
//   DATA_WIDTH  8   operand width; MAC result width ACC_W = 3*DATA_WIDTH
//   MAC_LAT     1   cycles from MAC En-sampled edge to Cout updated (>=1)
//   LEN_W       16  element-counter width (optional feature only)
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous, active-high reset
//   s_valid    in   1          operand pair valid
//   s_ready    out  1          feeder can accept a pair
//   s_a        in   DATA_WIDTH operand A
//   s_b        in   DATA_WIDTH operand B
//   s_last     in   1          pair is last element of the vector
//   mac_en     out  1          to MAC En
//   mac_clr    out  1          to MAC Clr
//   mac_a      out  DATA_WIDTH to MAC Ain
//   mac_b      out  DATA_WIDTH to MAC Bin
//   mac_cout   in   ACC_W      from MAC Cout
//   res_valid  out  1          result valid
//   res_ready  in   1          result consumer ready
//   res_data   out  ACC_W      captured dot-product
// BEHAVIOUR
//   - Reset: state RUN; mac_en, mac_clr, mac_a, mac_b, res_valid, res_data = 0.
//     MAC shares the same reset (inverted at top if active-low); no Clr at reset.
//   - States: RUN -> DRAIN -> HOLD -> CLEAR -> RUN.
//   - RUN: s_ready=1. Beat accepted on (s_valid & s_ready) at edge E.
//     mac_en=1, mac_a=s_a, mac_b=s_b are registered: high for exactly one cycle after E.
//     No accept -> mac_en=0 next cycle; mac_a/mac_b hold their last value.
//     Accepted beat with s_last=1 -> DRAIN.
//   - DRAIN: s_ready=0, mac_en=0. Wait counter loaded with MAC_LAT.
//     At the edge where the counter expires, res_data<=mac_cout and res_valid<=1 -> HOLD.
//     res_valid is visible MAC_LAT+1 cycles after the last-beat accept edge.
//   - HOLD: s_ready=0. res_valid and res_data stay stable until res_ready.
//     On (res_valid & res_ready): res_valid<=0 -> CLEAR.
//   - CLEAR: mac_clr=1 for exactly one cycle; s_ready=0 -> RUN.
//     mac_clr is registered, with the same timing as mac_en.
//   - Single-element vector (s_last on first beat) is legal.
//     Empty vectors are impossible.
//   - res_ready high while res_valid low: ignored.
//     res_ready held high: handshake completes on the first res_valid cycle.
//   - Arithmetic is done in the MAC. The feeder only copies mac_cout at full ACC_W, unmodified.
//   - Reset mid-vector or mid-HOLD: all outputs go to reset values and any pending result is dropped.
//     The next vector starts from a zero accumulator (MAC reset too).
// CONFIGURATION
//   MAC_FEEDER_LEN_EN defined:
//     - Adds port res_len out LEN_W: number of beats in the captured vector, loaded with res_data.
//     - Counter resets to 0 in CLEAR and saturates at 2^LEN_W-1.
//     - Reset value 0.
//   Undefined: no res_len port, no counter; all other behaviour identical.
// STRUCTURE
//   Package mac_pkg:
//     - state enum typedef (RUN, DRAIN, HOLD, CLEAR)
//     - localparam function acc_w(DATA_WIDTH) = 3*DATA_WIDTH
//   Single flat module, no sub-module; FSM, wait counter and result register inline.
// TESTING (bench instantiates mac_feeder + MAC, MAC_LAT=1)
//   1. Vector (3,2),(4,3),(1,5)last -> res_data=23; res_valid 2 cycles after last accept;
//      mac_en high 3 cycles total.
//   2. After (1) handshake, vector (2,6),(3,7)last -> one mac_clr pulse between vectors;
//      res_data=33.
//   3. res_ready low 10 cycles in HOLD -> res_valid held, res_data stable, s_ready=0,
//      mac_en=0 throughout.
//   4. Single beat (255,255)last -> res_data=65025.
//   5. s_valid toggled with 2-cycle gaps over (3,2),(4,3)last -> mac_en only after accepted beats;
//      res_data=18.
//   6. rst pulsed after 2nd beat of (1) -> outputs 0 next cycle;
//      subsequent (2,6),(3,7)last gives 33, not polluted.
//   7. MAC_FEEDER_LEN_EN builds: test (1) -> res_len=3; test (4) -> res_len=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC operand feeder.
package mac_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  function automatic int acc_w(input int data_width);
    return 3 * data_width;
  endfunction

endpackage

// File: rtl/mac_feeder.sv
// Streams (A,B) pairs into an external MAC, captures the dot-product at end of
// vector, hands it out on a valid/ready port, then clears the MAC.
// Optional feature: define MAC_FEEDER_LEN_EN to add the res_len beat count.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAC_LAT    = 1,
`ifdef MAC_FEEDER_LEN_EN
  parameter int LEN_W      = 16,
`endif
  localparam int ACC_W     = acc_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a,
  input  logic [DATA_WIDTH-1:0] s_b,
  input  logic                  s_last,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_W-1:0]      mac_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data
`ifdef MAC_FEEDER_LEN_EN
  ,
  output logic [LEN_W-1:0]      res_len
`endif
);

  localparam int WAIT_W = $clog2(MAC_LAT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              capture;

  // Ready is a pure decode of the registered state, so it is glitch-free and
  // carries no combinational path from s_valid.
  assign s_ready = (state == RUN);
  assign accept  = s_valid && s_ready;
  // The counter is loaded with MAC_LAT on the last accept and captured when it
  // reaches zero, i.e. MAC_LAT+1 edges after that accept.
  assign capture = (state == DRAIN) && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch sees the
      // pre-edge values and the defaults below are cleanly overridden.
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      unique case (state)
        RUN: begin
          if (accept) begin
            mac_en <= 1'b1;
            mac_a  <= s_a;
            mac_b  <= s_b;
            if (s_last) begin
              state    <= DRAIN;
              wait_cnt <= WAIT_W'(MAC_LAT);
            end
          end
        end
        DRAIN: begin
          if (capture) begin
            res_data  <= mac_cout;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            mac_clr   <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef MAC_FEEDER_LEN_EN
  logic [LEN_W-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      res_len  <= '0;
    end else begin
      if (state == CLEAR) begin
        beat_cnt <= '0;
      end else if (accept && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (capture) begin
        res_len <= beat_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural MAC and a transaction-level
// reference model checked every cycle.
module tb_mac_feeder;
  import mac_pkg::*;

  localparam int DW      = 8;
  localparam int MAC_LAT = 1;
  localparam int ACC_W   = acc_w(DW);
`ifdef MAC_FEEDER_LEN_EN
  localparam int LEN_W   = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [DW-1:0]    s_a, s_b;
  logic             mac_en, mac_clr;
  logic [DW-1:0]    mac_a, mac_b;
  logic [ACC_W-1:0] mac_cout;
  logic             res_valid, res_ready;
  logic [ACC_W-1:0] res_data;
`ifdef MAC_FEEDER_LEN_EN
  logic [LEN_W-1:0] res_len;
`endif

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int lat;

  always #5 clk = ~clk;

  mac_feeder #(.DATA_WIDTH(DW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_a(s_a),
    .s_b(s_b),
    .s_last(s_last),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_cout(mac_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
`ifdef MAC_FEEDER_LEN_EN
    ,
    .res_len(res_len)
`endif
  );

  // Behavioural MAC: one-cycle latency accumulator sharing the feeder reset.
  always @(posedge clk) begin
    if (rst)          mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: tracks the vector sum and the result/clear timeline.
  bit m_busy = 0, m_rv = 0, m_clearing = 0, m_en = 0, m_clr = 0;
  int m_wait = 0, m_sum = 0, m_len = 0, m_res = 0, m_rlen = 0;
  int m_a = 0, m_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rv = 0; m_clearing = 0; m_en = 0; m_clr = 0;
      m_wait = 0; m_sum = 0; m_len = 0; m_res = 0; m_rlen = 0; m_a = 0; m_b = 0;
    end else begin
      m_en  = 0;
      m_clr = 0;
      if (!m_busy) begin
        if (s_valid) begin
          m_sum += int'(s_a) * int'(s_b);
          m_len++;
          m_en = 1; m_a = int'(s_a); m_b = int'(s_b);
          if (s_last) begin
            m_busy = 1; m_wait = MAC_LAT + 1;
            m_res = m_sum; m_rlen = m_len; m_sum = 0; m_len = 0;
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_rv = 1;
      end else if (m_rv) begin
        if (res_ready) begin m_rv = 0; m_clr = 1; m_clearing = 1; end
      end else if (m_clearing) begin
        m_clearing = 0; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("s_ready", s_ready, !m_busy);
    check("mac_en", mac_en, m_en);
    check("mac_clr", mac_clr, m_clr);
    check("mac_a", mac_a, m_a);
    check("mac_b", mac_b, m_b);
    check("res_valid", res_valid, m_rv);
    if (m_rv) begin
      check("res_data", res_data, m_res);
`ifdef MAC_FEEDER_LEN_EN
      check("res_len", res_len, m_rlen);
`endif
    end
    if (mac_en)  en_cnt++;
    if (mac_clr) clr_cnt++;
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic send(input int a, input int b, input bit last);
    int budget = 0;
    s_valid = 1'b1; s_a = DW'(a); s_b = DW'(b); s_last = last;
    while (!s_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) check("s_ready_timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_res(output int edges);
    edges = 0;
    while (!res_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    if (!res_valid) check("res_valid_timeout", res_valid, 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_s_ready", s_ready, 1);
    check("rst_mac_en", mac_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);

    // 1: three-beat vector
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    en_cnt = 0;
    send(3, 2, 0); send(4, 3, 0); send(1, 5, 1);
    wait_res(lat);
    check("t1_latency", lat, 2);
    check("t1_res", res_data, 23);
    check("t1_en_cnt", en_cnt, 3);
`ifdef MAC_FEEDER_LEN_EN
    check("t1_len", res_len, 3);
`endif
    clr_cnt = 0;
    handshake();

    // 2: second vector after one clear pulse
    send(2, 6, 0); send(3, 7, 1);
    wait_res(lat);
    check("t2_res", res_data, 33);
    check("t2_clr_cnt", clr_cnt, 1);

    // 3: consumer stalls in HOLD
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_valid", res_valid, 1);
      check("t3_data", res_data, 33);
      check("t3_s_ready", s_ready, 0);
      check("t3_mac_en", mac_en, 0);
    end
    handshake();

    // 4: single full-scale beat
    send(255, 255, 1);
    wait_res(lat);
    check("t4_res", res_data, 65025);
`ifdef MAC_FEEDER_LEN_EN
    check("t4_len", res_len, 1);
`endif
    handshake();

    // 5: gaps between beats
    en_cnt = 0;
    send(3, 2, 0);
    repeat (2) @(negedge clk);
    send(4, 3, 1);
    wait_res(lat);
    check("t5_res", res_data, 18);
    check("t5_en_cnt", en_cnt, 2);
    handshake();

    // 6: reset mid-vector, then a clean vector
    send(3, 2, 0); send(4, 3, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_mac_en", mac_en, 0);
    check("t6_mac_clr", mac_clr, 0);
    check("t6_mac_a", mac_a, 0);
    check("t6_mac_b", mac_b, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_data", res_data, 0);
    check("t6_s_ready", s_ready, 1);
    send(2, 6, 0); send(3, 7, 1);
    wait_res(lat);
    check("t6_res", res_data, 33);
    handshake();

    // reset while a result is held drops it
    send(1, 5, 1);
    wait_res(lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6b_res_valid", res_valid, 0);
    send(2, 2, 1);
    wait_res(lat);
    check("t6b_res", res_data, 4);
    handshake();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
